// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// saturating to all nines when the value does not fit in DIGITS digits.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e          state_q, state_d;
    logic [BIN_W-1:0] shreg_q, shreg_d;
    logic [SW-1:0]   scratch_q, scratch_d, scratch_adj;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_int_q, ovf_int_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_int_d  = ovf_int_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StConv;
                    shreg_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(BIN_W);
                    ovf_int_d = 1'b0;
                end
            end
            StConv: begin
                scratch_d = {scratch_adj[SW-2:0], shreg_q[BIN_W-1]};
                shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
                ovf_int_d = ovf_int_q | scratch_adj[SW-1];
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    overflow_d = ovf_int_d;
                    bcd_d      = ovf_int_d ? {DIGITS{4'h9}} : scratch_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_int_q  <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_int_q  <= ovf_int_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == StConv);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
